da2_transmitter: RTL
====================

Name: da2_transmitter

Overview:
- Drives the Pmod DA2 (dual DAC121S101) over its 3-wire serial interface. It is the audio output counterpart to the microphone capture path.
- On each sample strobe it latches two 12-bit unsigned samples (channel A, channel B). It shifts them out MSB-first as 16-bit frames on shared SYNC/SCLK lines and two data lines.
- Sits beside the capture path, fed from the 20 kHz sample strobe. Its pins map to a spare Pmod header.

Parameters:
- CLK_DIV, 2, system clocks per SCLK half-period. Legal range 1..255; SCLK = f_clk / (2*CLK_DIV).
- QUIET, 4, system clocks with SYNC held high after a frame before the next frame may begin. Legal range 1..255.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to send the sample pair
- sample_a  in  12  channel A sample, unsigned offset binary
- sample_b  in  12  channel B sample, unsigned offset binary
- pd  in  2  DAC power-down bits, sent in both frames (00 = normal)
- sync_n  out  1  DA2 SYNC, active low
- sclk  out  1  DA2 serial clock
- dina  out  1  serial data, DAC A
- dinb  out  1  serial data, DAC B
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at frame end
- overrun  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, takes effect immediately, including mid-frame):
  - sync_n=1, sclk=1, dina=0, dinb=0, busy=0, done=0, overrun=0.
  - State IDLE, all counters 0.
- Frame word, identical layout per channel: {2'b00, pd, sample}, 16 bits, sent bit15 first.
- States: IDLE, SHIFT, QUIET.
- IDLE:
  - sclk=1, sync_n=1.
  - start=1 sampled at a clk edge → at that edge:
    - latch shift_a={2'b00,pd,sample_a} and shift_b={2'b00,pd,sample_b};
    - sync_n<=0; dina/dinb<=bit15; bit counter<=0; divider<=0;
    - enter SHIFT. busy goes high that edge.
- SHIFT:
  - Divider counts 0..CLK_DIV-1. On wrap, sclk toggles.
  - High→low toggle: DAC samples the current bit; no data change.
  - Low→high toggle: next bit is driven on dina/dinb and the bit counter increments. Data is always stable for a full half-period either side of each falling edge.
  - After the 16th falling edge's low half-period completes:
    - sclk<=1, sync_n<=1, dina/dinb<=0;
    - done pulses high for that one cycle;
    - enter QUIET.
  - sync_n low duration is exactly 32*CLK_DIV clocks. There are exactly 16 falling sclk edges per frame.
- QUIET:
  - Hold sync_n=1, sclk=1 for QUIET clocks, then go to IDLE.
  - busy drops on entry to IDLE.
  - Earliest next accepted start: first cycle in IDLE. Total sync_n fall-to-fall minimum is 32*CLK_DIV+QUIET+1 clocks.
- start while busy (SHIFT or QUIET):
  - Ignored; overrun pulses one cycle coincident with the next edge.
  - Latched data and timing are unaffected.
  - start held high for multiple cycles in IDLE launches exactly one frame; subsequent cycles raise overrun.
- Inputs (sample_a, sample_b, pd) are sampled only at the accepting edge. Changes mid-frame have no effect.
- No output glitches: all outputs are registered.

Test Plan:
- Reset mid-frame: assert rst_n=0 at clock 20 of a frame → same delta: sync_n=1, sclk=1, dina=dinb=0, busy=0. Next start sends a clean full frame.
- Basic frame, CLK_DIV=2, QUIET=4, pd=00, sample_a=12'hA5C, sample_b=12'h3F0, one-cycle start:
  - sync_n low exactly 64 clocks; 16 sclk falling edges.
  - Bits captured at falling edges: A=16'h0A5C, B=16'h03F0.
  - done pulses once on the sync_n rising cycle; busy low 4 clocks later.
- Power-down/extremes, pd=2'b11, sample_a=12'hFFF, sample_b=12'h000 → A=16'h3FFF, B=16'h3000.
- Overrun:
  - start at frame accept and again 10 clocks later → one overrun pulse; frame data is unchanged.
  - start during QUIET → overrun pulse, no new frame.
  - start on the first IDLE cycle → accepted with no overrun.
- Held start: start high 5 consecutive cycles from IDLE → exactly one frame; overrun pulses on the 4 following cycles.
- Timing, CLK_DIV=1 → sync_n low 32 clocks, sclk period 2 clocks, data changes only on sclk rising. Repeat with CLK_DIV=5 → low 160 clocks.

Source files
------------

// File: rtl/da2_transmitter.sv
// da2_transmitter: serial driver for the Pmod DA2 (dual DAC121S101).
// Latches a pair of 12-bit samples on start and shifts them out MSB-first
// as 16-bit frames {2'b00, pd, sample} on shared SYNC/SCLK lines, one data
// line per DAC. Every output is driven straight from a flop.
module da2_transmitter #(
    parameter int CLK_DIV = 2,   // system clocks per SCLK half-period (1..255)
    parameter int QUIET   = 4    // clocks of SYNC high after a frame (1..255)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] sample_a,
    input  logic [11:0] sample_b,
    input  logic [1:0]  pd,
    output logic        sync_n,
    output logic        sclk,
    output logic        dina,
    output logic        dinb,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET - 1);

    state_t      state_reg, state_next;
    logic [7:0]  div_reg, div_next;
    logic [3:0]  bit_reg, bit_next;
    logic [7:0]  quiet_reg, quiet_next;
    logic [15:0] shift_a_reg, shift_a_next;
    logic [15:0] shift_b_reg, shift_b_next;
    logic        sync_n_reg, sync_n_next;
    logic        sclk_reg, sclk_next;
    logic        dina_reg, dina_next;
    logic        dinb_reg, dinb_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        overrun_reg, overrun_next;

    logic [15:0] frame_a;
    logic [15:0] frame_b;
    logic        div_wrap;
    logic        frame_end;
    logic        quiet_end;

    // Frame words as they would be latched at an accepting edge.
    assign frame_a = {2'b00, pd, sample_a};
    assign frame_b = {2'b00, pd, sample_b};

    // A half-period ends when the divider reaches its last count.
    assign div_wrap  = (div_reg == DIV_LAST);
    // The frame ends where the 16th low half-period would turn sclk high.
    assign frame_end = (state_reg == ST_SHIFT) && div_wrap && !sclk_reg && (bit_reg == 4'd15);
    assign quiet_end = (state_reg == ST_QUIET) && (quiet_reg == QUIET_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> QUIET at frame end, QUIET -> IDLE after the gap.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start)     state_next = ST_SHIFT;
            ST_SHIFT: if (frame_end) state_next = ST_QUIET;
            ST_QUIET: if (quiet_end) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Datapath and output next values; outputs are registered below so nothing glitches.
    always_comb begin
        div_next     = div_reg;
        bit_next     = bit_reg;
        quiet_next   = quiet_reg;
        shift_a_next = shift_a_reg;
        shift_b_next = shift_b_reg;
        sync_n_next  = sync_n_reg;
        sclk_next    = sclk_reg;
        dina_next    = dina_reg;
        dinb_next    = dinb_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        // A request that arrives while a frame or its quiet gap is in progress is dropped.
        overrun_next = start && (state_reg != ST_IDLE);

        unique case (state_reg)
            ST_IDLE: begin
                sync_n_next = 1'b1;
                sclk_next   = 1'b1;
                if (start) begin
                    shift_a_next = frame_a;
                    shift_b_next = frame_b;
                    sync_n_next  = 1'b0;
                    dina_next    = frame_a[15];
                    dinb_next    = frame_b[15];
                    bit_next     = 4'd0;
                    div_next     = 8'd0;
                    busy_next    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_wrap) begin
                    div_next = 8'd0;
                    if (sclk_reg) begin
                        // Falling edge: the DAC samples the bit already on the line.
                        sclk_next = 1'b0;
                    end else if (bit_reg == 4'd15) begin
                        // Last low half-period done: close the frame.
                        sclk_next   = 1'b1;
                        sync_n_next = 1'b1;
                        dina_next   = 1'b0;
                        dinb_next   = 1'b0;
                        done_next   = 1'b1;
                        quiet_next  = 8'd0;
                    end else begin
                        // Rising edge: present the next bit, current bit lives in [15].
                        sclk_next    = 1'b1;
                        bit_next     = bit_reg + 4'd1;
                        shift_a_next = shift_a_reg << 1;
                        shift_b_next = shift_b_reg << 1;
                        dina_next    = shift_a_reg[14];
                        dinb_next    = shift_b_reg[14];
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            ST_QUIET: begin
                if (quiet_end) begin
                    quiet_next = 8'd0;
                    busy_next  = 1'b0;
                end else begin
                    quiet_next = quiet_reg + 8'd1;
                end
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg     <= 8'd0;
            bit_reg     <= 4'd0;
            quiet_reg   <= 8'd0;
            shift_a_reg <= 16'd0;
            shift_b_reg <= 16'd0;
            sync_n_reg  <= 1'b1;
            sclk_reg    <= 1'b1;
            dina_reg    <= 1'b0;
            dinb_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            div_reg     <= div_next;
            bit_reg     <= bit_next;
            quiet_reg   <= quiet_next;
            shift_a_reg <= shift_a_next;
            shift_b_reg <= shift_b_next;
            sync_n_reg  <= sync_n_next;
            sclk_reg    <= sclk_next;
            dina_reg    <= dina_next;
            dinb_reg    <= dinb_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
        end
    end

    assign sync_n  = sync_n_reg;
    assign sclk    = sclk_reg;
    assign dina    = dina_reg;
    assign dinb    = dinb_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign overrun = overrun_reg;

endmodule
